// File: rtl/enclave_op_scheduler.sv
// enclave_op_scheduler: two-port round-robin command queue feeding the shared
// crypto controller, with a settle cycle after configure and a run watchdog.
module enclave_op_scheduler #(
    parameter int ADDR_WIDTH      = 10,
    parameter int QUEUE_DEPTH     = 4,
    parameter int QUEUE_PTR_WIDTH = 2,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int TIMER_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0_valid,
    input  logic [2+3*ADDR_WIDTH-1:0]   req0_cmd,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [2+3*ADDR_WIDTH-1:0]   req1_cmd,
    output logic                        req1_ready,
    output logic                        ctrl_config_en,
    output logic [1:0]                  ctrl_opcode,
    output logic [ADDR_WIDTH-1:0]       ctrl_op1_base_addr,
    output logic [ADDR_WIDTH-1:0]       ctrl_op2_base_addr,
    output logic [ADDR_WIDTH-1:0]       ctrl_out_base_addr,
    input  logic                        ctrl_done,
    output logic                        cmd_done,
    output logic                        cmd_done_src,
    output logic                        timeout_err,
    input  logic                        clear_err,
    output logic                        busy,
    output logic [QUEUE_PTR_WIDTH:0]    queue_count
);
    localparam int CMD_W = 2 + 3 * ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CONFIG, SETTLE, RUN} state_t;

    state_t                     state;
    logic [CMD_W-1:0]           q_cmd [QUEUE_DEPTH];
    logic                       q_src [QUEUE_DEPTH];
    logic [QUEUE_PTR_WIDTH-1:0] wr_ptr;
    logic [QUEUE_PTR_WIDTH-1:0] rd_ptr;
    logic [QUEUE_PTR_WIDTH:0]   count;
    logic                       last_grant;
    logic                       src_q;
    logic [TIMER_WIDTH-1:0]     wdog;
    logic                       full;
    logic                       grant0;
    logic                       grant1;
    logic                       push;
    logic                       pop;

    // Ready is gated by rst_n so every output reads 0 while reset is held.
    assign full   = count == (QUEUE_PTR_WIDTH+1)'(QUEUE_DEPTH);
    assign grant0 = rst_n && !full && req0_valid && (!req1_valid || last_grant);
    assign grant1 = rst_n && !full && req1_valid && (!req0_valid || !last_grant);
    assign push   = grant0 | grant1;
    assign pop    = state == CONFIG;

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign cmd_done     = (state == RUN) && ctrl_done;
    assign cmd_done_src = src_q;
    assign busy         = (state != IDLE) || (count != '0);
    assign queue_count  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            q_cmd[wr_ptr] <= grant1 ? req1_cmd : req0_cmd;
            q_src[wr_ptr] <= grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head fields are loaded on the IDLE->CONFIG edge so they are valid
    // together with the configure pulse and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ctrl_config_en     <= 1'b0;
            ctrl_opcode        <= '0;
            ctrl_op1_base_addr <= '0;
            ctrl_op2_base_addr <= '0;
            ctrl_out_base_addr <= '0;
            src_q              <= 1'b0;
            wdog               <= '0;
            timeout_err        <= 1'b0;
        end else begin
            ctrl_config_en <= 1'b0;
            if (clear_err) begin
                timeout_err <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state          <= CONFIG;
                        ctrl_config_en <= 1'b1;
                        {ctrl_opcode, ctrl_op1_base_addr,
                         ctrl_op2_base_addr, ctrl_out_base_addr} <= q_cmd[rd_ptr];
                        src_q          <= q_src[rd_ptr];
                    end
                end
                CONFIG: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    wdog  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    wdog <= wdog + 1'b1;
                    if (ctrl_done) begin
                        state <= IDLE;
                    end else if (wdog == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_enclave_op_scheduler.sv
// Bench for enclave_op_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_enclave_op_scheduler;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int TO    = 255;
    localparam int CW    = 2 + 3 * AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic          req1_valid = 1'b0;
    logic [CW-1:0] req0_cmd = '0;
    logic [CW-1:0] req1_cmd = '0;
    logic          ctrl_done = 1'b0;
    logic          clear_err = 1'b0;
    logic          req0_ready, req1_ready, ctrl_config_en;
    logic [1:0]    ctrl_opcode;
    logic [AW-1:0] ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr;
    logic          cmd_done, cmd_done_src, timeout_err, busy;
    logic [2:0]    queue_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enclave_op_scheduler #(
        .ADDR_WIDTH(AW), .QUEUE_DEPTH(DEPTH), .QUEUE_PTR_WIDTH(2),
        .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
        .ctrl_config_en(ctrl_config_en), .ctrl_opcode(ctrl_opcode),
        .ctrl_op1_base_addr(ctrl_op1_base_addr),
        .ctrl_op2_base_addr(ctrl_op2_base_addr),
        .ctrl_out_base_addr(ctrl_out_base_addr),
        .ctrl_done(ctrl_done), .cmd_done(cmd_done), .cmd_done_src(cmd_done_src),
        .timeout_err(timeout_err), .clear_err(clear_err),
        .busy(busy), .queue_count(queue_count)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: FIFO of {src,cmd}, and the age of the command in
    // flight (-1 none, 0 configure cycle, 1 settle, 2+ running).
    logic [CW:0] mq[$];
    logic        m_last = 1'b1;
    int          m_age = -1;
    logic        m_err = 1'b0;
    logic [CW:0] m_cur = '0;
    logic        e_win, e_grant, e_done, e_set;
    int          e_sz;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_last = 1'b1;
            m_age  = -1;
            m_err  = 1'b0;
            m_cur  = '0;
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_cfg", ctrl_config_en, 0);
            chk("rst_ctrl", {ctrl_opcode, ctrl_op1_base_addr,
                             ctrl_op2_base_addr, ctrl_out_base_addr}, 0);
            chk("rst_done", cmd_done, 0);
            chk("rst_err", timeout_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_count", queue_count, 0);
        end else begin
            e_sz    = mq.size();
            e_win   = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_grant = (e_sz < DEPTH) && (req0_valid || req1_valid);
            e_done  = (m_age >= 2) && ctrl_done;
            chk("m_ready0", req0_ready, e_grant && !e_win);
            chk("m_ready1", req1_ready, e_grant && e_win);
            chk("m_cfg", ctrl_config_en, m_age == 0);
            chk("m_ctrl", {ctrl_opcode, ctrl_op1_base_addr,
                           ctrl_op2_base_addr, ctrl_out_base_addr}, m_cur[CW-1:0]);
            chk("m_done", cmd_done, e_done);
            if (e_done) chk("m_src", cmd_done_src, m_cur[CW]);
            chk("m_err", timeout_err, m_err);
            chk("m_busy", busy, (m_age != -1) || (e_sz != 0));
            chk("m_count", queue_count, e_sz);
            e_set = 1'b0;
            if (m_age == 0) begin
                void'(mq.pop_front());
                m_age = 1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age >= 2) begin
                if (ctrl_done) m_age = -1;
                else if (m_age - 2 == TO - 1) begin
                    m_age = -1;
                    e_set = 1'b1;
                end else m_age++;
            end else if (e_sz != 0) begin
                m_age = 0;
                m_cur = mq[0];
            end
            if (e_grant) begin
                mq.push_back({e_win, e_win ? req1_cmd : req0_cmd});
                m_last = e_win;
            end
            if (e_set) m_err = 1'b1;
            else if (clear_err) m_err = 1'b0;
        end
    end

    int   s_age = 0;
    int   s_delay = 1000;
    logic s_stale = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller stub: done level is arbitrary during configure/settle,
    // then rises s_delay cycles after the configure pulse.
    task automatic drive_random();
        if (ctrl_config_en) begin
            s_age   = 0;
            s_stale = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       s_delay = 256;
                1:       s_delay = 257;
                2:       s_delay = 1000;
                default: s_delay = $urandom_range(2, 14);
            endcase
        end else if (s_age < 5000) s_age++;
        ctrl_done  = (s_age < 2) ? s_stale : (s_age >= s_delay);
        req0_valid = $urandom_range(0, 2) != 0;
        req1_valid = $urandom_range(0, 2) != 0;
        req0_cmd   = $urandom;
        req1_cmd   = $urandom;
        clear_err  = $urandom_range(0, 24) == 0;
    endtask

    task automatic chk_all_zero();
        chk("ar_ready0", req0_ready, 0);
        chk("ar_ready1", req1_ready, 0);
        chk("ar_cfg", ctrl_config_en, 0);
        chk("ar_op", ctrl_opcode, 0);
        chk("ar_a1", ctrl_op1_base_addr, 0);
        chk("ar_a2", ctrl_op2_base_addr, 0);
        chk("ar_a3", ctrl_out_base_addr, 0);
        chk("ar_done", cmd_done, 0);
        chk("ar_src", cmd_done_src, 0);
        chk("ar_err", timeout_err, 0);
        chk("ar_busy", busy, 0);
        chk("ar_count", queue_count, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // single port-0 ADD command, done 12 cycles after configure
        tick();
        req0_valid = 1'b1;
        req0_cmd   = {2'b10, 10'h010, 10'h020, 10'h030};
        #1 chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1 chk("t1_count", queue_count, 1);
        chk("t1_cfg_early", ctrl_config_en, 0);
        tick();
        chk("t1_cfg", ctrl_config_en, 1);
        chk("t1_op", ctrl_opcode, 2);
        chk("t1_a1", ctrl_op1_base_addr, 'h010);
        chk("t1_a2", ctrl_op2_base_addr, 'h020);
        chk("t1_a3", ctrl_out_base_addr, 'h030);
        tick();
        chk("t1_cfg_once", ctrl_config_en, 0);
        repeat (11) tick();
        ctrl_done = 1'b1;
        #1 chk("t1_done", cmd_done, 1);
        chk("t1_src", cmd_done_src, 0);
        chk("t1_busy_run", busy, 1);
        tick();
        ctrl_done = 1'b0;
        #1 chk("t1_done_off", cmd_done, 0);
        chk("t1_busy_off", busy, 0);

        // stale done held through configure and settle
        tick();
        ctrl_done  = 1'b1;
        req1_valid = 1'b1;
        req1_cmd   = {2'b11, 10'h3ff, 10'h001, 10'h200};
        #1 chk("t3_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        #1 chk("t3_idle", cmd_done, 0);
        tick();
        chk("t3_cfg", ctrl_config_en, 1);
        chk("t3_cfg_done", cmd_done, 0);
        tick();
        chk("t3_settle", cmd_done, 0);
        tick();
        ctrl_done = 1'b0;
        #1 chk("t3_run0", cmd_done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_wait", cmd_done, 0);
        end
        tick();
        ctrl_done = 1'b1;
        #1 chk("t3_done", cmd_done, 1);
        chk("t3_src", cmd_done_src, 1);
        tick();
        ctrl_done = 1'b0;
        #1 chk("t3_busy", busy, 0);

        // both ports valid, controller stalled; then full queue with a pop
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req0_cmd = $urandom;
            req1_cmd = $urandom;
            #1 chk("t2_ready0", req0_ready, (c % 2) == 0);
            chk("t2_ready1", req1_ready, (c % 2) == 1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("t2_full_cnt", queue_count, 4);
            chk("t2_full_r0", req0_ready, 0);
            chk("t2_full_r1", req1_ready, 0);
        end
        tick();
        ctrl_done = 1'b1;
        #1 chk("t2_done", cmd_done, 1);
        tick();
        ctrl_done = 1'b0;
        #1 chk("t6_idle_cnt", queue_count, 4);
        tick();
        chk("t6_cfg", ctrl_config_en, 1);
        chk("t6_cfg_cnt", queue_count, 4);
        chk("t6_cfg_r0", req0_ready, 0);
        chk("t6_cfg_r1", req1_ready, 0);
        tick();
        chk("t6_after_cnt", queue_count, 3);
        chk("t6_after_r0", req0_ready, 0);
        chk("t6_after_r1", req1_ready, 1);

        // randomized traffic including late-done and timeout delays
        s_age   = 1;
        s_delay = 5;
        s_stale = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            drive_random();
        end

        // drain with done high and errors cleared
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ctrl_done  = 1'b1;
        clear_err  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy && !timeout_err) break;
        end
        chk("drain_busy", busy, 0);
        chk("drain_err", timeout_err, 0);

        // async reset mid-run with three commands queued
        ctrl_done  = 1'b0;
        clear_err  = 1'b0;
        req0_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req0_cmd = $urandom;
            tick();
        end
        req0_valid = 1'b0;
        #1 chk("t5_count", queue_count, 3);
        chk("t5_busy", busy, 1);
        #1 rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1 chk_all_zero();
        @(posedge clk);
        #3 rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        req1_valid = 1'b1;
        req1_cmd   = {2'b01, 10'h155, 10'h2aa, 10'h0f0};
        #1 chk("t5_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t5_cfg", ctrl_config_en, 1);
        chk("t5_op", ctrl_opcode, 1);
        chk("t5_a1", ctrl_op1_base_addr, 'h155);
        chk("t5_a3", ctrl_out_base_addr, 'h0f0);
        repeat (3) tick();
        ctrl_done = 1'b1;
        #1 chk("t5_done", cmd_done, 1);
        chk("t5_src", cmd_done_src, 1);
        tick();
        ctrl_done = 1'b0;
        #1 chk("t5_busy", busy, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/enclave_op_scheduler.md
Name: enclave_op_scheduler

Overview:
- Shares the single encrypt/decrypt/add/mult controller between two command requesters (host port 0, host port 1).
- Round-robin arbitrates requests into a small command queue. Pops one command at a time and drives the controller's configure interface.
- Waits for the controller's done, then reports completion with the source ID.
- Includes a watchdog against a controller that never completes.

Parameters:
- ADDR_WIDTH, 10, width of each base address.
- QUEUE_DEPTH, 4, command queue entries (power of two).
- QUEUE_PTR_WIDTH, 2, log2(QUEUE_DEPTH).
- TIMEOUT_CYCLES, 255, max RUN cycles before watchdog fires (must be at least 1).
- TIMER_WIDTH, 8, watchdog counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 command valid
- req0_cmd  in  2+3*ADDR_WIDTH  port 0 command: {opcode[1:0], op1_base, op2_base, out_base}
- req0_ready  out  1  port 0 command accepted this cycle
- req1_valid  in  1  port 1 command valid
- req1_cmd  in  2+3*ADDR_WIDTH  port 1 command, same packing as req0_cmd
- req1_ready  out  1  port 1 command accepted this cycle
- ctrl_config_en  out  1  one-cycle configure pulse to controller
- ctrl_opcode  out  2  opcode to controller
- ctrl_op1_base_addr  out  ADDR_WIDTH  op1 base address
- ctrl_op2_base_addr  out  ADDR_WIDTH  op2 base address
- ctrl_out_base_addr  out  ADDR_WIDTH  output base address
- ctrl_done  in  1  controller done level
- cmd_done  out  1  one-cycle completion pulse
- cmd_done_src  out  1  source port of completed command
- timeout_err  out  1  sticky watchdog error
- clear_err  in  1  clears timeout_err
- busy  out  1  FSM not in IDLE, or queue not empty
- queue_count  out  QUEUE_PTR_WIDTH+1  occupied entries

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; queue empty; FSM in IDLE; watchdog counter 0.
  - Last-grant register = 1, so port 0 wins the first tie.
  - Reset mid-command abandons it; queue contents are lost.
- Arbitration (combinational ready, registered enqueue):
  - If queue not full: grant the single valid port. If both are valid, grant the port that was not last granted.
  - reqN_ready=1 only for the granted port. At most one enqueue per cycle.
  - Last-grant updates only on an actual enqueue.
  - Full queue: both ready=0. No bypass, even in a cycle where a pop occurs.
- Queue:
  - FIFO; each entry stores the command plus a 1-bit source ID.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Same-cycle push and pop leaves queue_count unchanged.
- FSM states: IDLE, CONFIG, SETTLE, RUN.
  - IDLE: if queue not empty, go to CONFIG.
  - CONFIG: pop the head entry; assert ctrl_config_en for exactly this cycle. ctrl_opcode and ctrl_*_base_addr are registered from the head entry and held until the next CONFIG. Latch source ID. Go to SETTLE.
  - SETTLE: one cycle; ctrl_done is ignored because it may be stale. Clear watchdog. Go to RUN.
  - RUN: watchdog increments each cycle.
    - If ctrl_done=1: pulse cmd_done=1 with cmd_done_src=latched source for one cycle; go to IDLE.
    - Else if watchdog reaches TIMEOUT_CYCLES-1: set timeout_err=1, no cmd_done pulse, drop the command, go to IDLE.
  - Back-to-back commands: IDLE→CONFIG adds one cycle. Minimum spacing between config pulses = 3 cycles plus controller run time.
- Error handling:
  - timeout_err is sticky. clear_err clears it next cycle.
  - A same-cycle set and clear leaves timeout_err=1 (set wins).
  - Scheduling continues while timeout_err=1.
- Pass-through:
  - Opcode values pass through unchecked; the controller decodes them.
  - busy = (state!=IDLE) | (queue_count!=0).

Test Plan:
1. Port 0 only, cmd {ADD, op1=0x010, op2=0x020, out=0x030}. ctrl_done rises 12 cycles after config.
   → one ctrl_config_en pulse carrying exact addresses; cmd_done pulse with src=0; busy drops the cycle after cmd_done.
2. Both ports valid every cycle, queue empty, controller stalled.
   → grants alternate 0,1,0,1; both ready=0 once queue_count=4.
   → After each completion, exactly one more enqueue; order of config pulses matches enqueue order.
3. Stale done: hold ctrl_done=1 through CONFIG and SETTLE, drop it on the RUN entry cycle, re-raise it 5 cycles later.
   → cmd_done fires only on the re-raise, never during SETTLE.
4. TIMEOUT_CYCLES=8, ctrl_done held 0.
   → timeout_err=1 after 8 RUN cycles; no cmd_done; next queued command configures.
   → clear_err pulse clears timeout_err.
5. Assert rst_n=0 asynchronously mid-RUN with 3 commands queued.
   → all outputs 0 immediately, queue_count=0.
   → After release, a new port-1 command is accepted and runs normally.
6. Queue full with a same-cycle pop in CONFIG.
   → ready stays 0 that cycle; queue_count goes 4→3; the next cycle accepts an enqueue.
